// File: rtl/fp16_sub_seq_if.sv
// Operand/result bundle for the half-precision subtractor: start/ready request
// side plus the one-cycle done pulse with its result.
interface fp16_sub_seq_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] z;

    modport master (output start, a, b, input ready, done, z);
    modport slave  (input start, a, b, output ready, done, z);
endinterface

// File: rtl/fp16_sub_seq.sv
// Multi-cycle binary16 subtractor z = a - b, round-to-nearest-even, flush-to-zero.
// One operation walks ALIGN, SUB, NORM, ROUND, PACK; done/z are registered out of PACK.
module fp16_sub_seq #(
    parameter logic [15:0] QNAN = 16'h7E00,
    parameter bit          FTZ  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    fp16_sub_seq_if.slave io
);
    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SUB, S_NORM, S_ROUND, S_PACK} state_t;
    state_t state_q, state_d;

    logic               accept;
    logic               sa_q, sb_q, sx_q, sy_q, s_q, spec_q, zero_q, done_q;
    logic signed [6:0]  ea_q, eb_q, e_q;
    logic [13:0]        ma_q, mb_q, mx_q, my_q, m_q;
    logic [14:0]        sum_q;
    logic [9:0]         frac_q;
    logic [15:0]        spec_z_q, z_q;

    function automatic logic signed [6:0] unbias(input logic [4:0] e);
        return $signed({2'b00, e}) - 7'sd15;
    endfunction

    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] n;
        n = 4'd14;
        for (int i = 0; i < 14; i++)
            if (v[i]) n = 4'(13 - i);
        return n;
    endfunction

    function automatic logic rne_inc(input logic [13:0] m);
        return m[2] && (m[1] || m[0] || m[3]);
    endfunction

    function automatic logic [15:0] pack(input logic s, input logic signed [6:0] e,
                                         input logic [9:0] f);
        if (e > 7'sd15)       return {s, 5'h1F, 10'h000};
        else if (e < -7'sd14) return 16'h0000;
        else                  return {s, 5'(e + 7'sd15), f};
    endfunction

    assign accept = io.start && io.ready;
    assign io.done = done_q;
    assign io.z    = z_q;

    // Operand classification; the special result is decided at accept time and carried along.
    logic        na, nb, ia, ib, za, zb, spec_d;
    logic [15:0] spec_z_d;
    always_comb begin
        za = (io.a[14:10] == 5'd0) && (FTZ || io.a[9:0] == 10'd0);
        zb = (io.b[14:10] == 5'd0) && (FTZ || io.b[9:0] == 10'd0);
        ia = (io.a[14:10] == 5'h1F) && (io.a[9:0] == 10'd0);
        ib = (io.b[14:10] == 5'h1F) && (io.b[9:0] == 10'd0);
        na = (io.a[14:10] == 5'h1F) && (io.a[9:0] != 10'd0);
        nb = (io.b[14:10] == 5'h1F) && (io.b[9:0] != 10'd0);
        spec_d   = 1'b1;
        spec_z_d = QNAN;
        if (na || nb)                          spec_z_d = QNAN;
        else if (ia && ib && io.a[15] == io.b[15]) spec_z_d = QNAN;
        else if (ia)                           spec_z_d = io.a;
        else if (ib)                           spec_z_d = {~io.b[15], 5'h1F, 10'h000};
        else if (za && zb)                     spec_z_d = {io.a[15] & ~io.b[15], 15'd0};
        else if (za)                           spec_z_d = {~io.b[15], io.b[14:0]};
        else if (zb)                           spec_z_d = io.a;
        else                                   spec_d   = 1'b0;
    end

    // ALIGN: larger exponent wins ties to a; shifted-out bits collapse into sticky.
    logic               a_big;
    logic signed [6:0]  diff;
    logic [3:0]         sh;
    logic [27:0]        ext;
    logic [13:0]        al_d;
    always_comb begin
        a_big = (ea_q >= eb_q);
        diff  = a_big ? ea_q - eb_q : eb_q - ea_q;
        sh    = (diff > 7'sd15) ? 4'd15 : diff[3:0];
        ext   = {(a_big ? mb_q : ma_q), 14'd0} >> sh;
        al_d  = {ext[27:15], ext[14] | (|ext[13:0])};
    end

    // SUB: magnitude add or larger-minus-smaller; an exact zero is always +0.
    logic [14:0] sum_d;
    logic        sgn_d;
    always_comb begin
        if (sx_q == sy_q) begin
            sum_d = {1'b0, mx_q} + {1'b0, my_q};
            sgn_d = sx_q;
        end else if (mx_q >= my_q) begin
            sum_d = {1'b0, mx_q} - {1'b0, my_q};
            sgn_d = sx_q;
        end else begin
            sum_d = {1'b0, my_q} - {1'b0, mx_q};
            sgn_d = sy_q;
        end
        if (sum_d == 15'd0) sgn_d = 1'b0;
    end

    logic [3:0]        lz;
    logic [13:0]       m_d;
    logic signed [6:0] en_d;
    always_comb begin
        lz = lzc14(sum_q[13:0]);
        if (sum_q[14]) begin
            m_d  = {sum_q[14:2], |sum_q[1:0]};
            en_d = e_q + 7'sd1;
        end else begin
            m_d  = sum_q[13:0] << lz;
            en_d = e_q - $signed({3'b000, lz});
        end
    end

    logic [11:0]       rnd;
    logic [9:0]        frac_d;
    logic signed [6:0] er_d;
    always_comb begin
        rnd = {1'b0, m_q[13:3]} + {11'd0, rne_inc(m_q)};
        if (rnd[11]) begin
            frac_d = rnd[10:1];
            er_d   = e_q + 7'sd1;
        end else begin
            frac_d = rnd[9:0];
            er_d   = e_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sa_q     <= io.a[15];
            sb_q     <= ~io.b[15];
            ea_q     <= unbias(io.a[14:10]);
            eb_q     <= unbias(io.b[14:10]);
            ma_q     <= {1'b1, io.a[9:0], 3'b000};
            mb_q     <= {1'b1, io.b[9:0], 3'b000};
            spec_q   <= spec_d;
            spec_z_q <= spec_z_d;
        end
        case (state_q)
            S_ALIGN: begin
                mx_q <= a_big ? ma_q : mb_q;
                my_q <= al_d;
                sx_q <= a_big ? sa_q : sb_q;
                sy_q <= a_big ? sb_q : sa_q;
                e_q  <= a_big ? ea_q : eb_q;
            end
            S_SUB: begin
                sum_q <= sum_d;
                s_q   <= sgn_d;
            end
            S_NORM: begin
                m_q <= m_d;
                e_q <= en_d;
            end
            S_ROUND: begin
                frac_q <= frac_d;
                e_q    <= er_d;
                zero_q <= (m_q == 14'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q    <= 16'h0000;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_PACK);
            if (state_q == S_PACK)
                z_q <= spec_q ? spec_z_q : (zero_q ? 16'h0000 : pack(s_q, e_q, frac_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        io.ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                io.ready = 1'b1;
                if (io.start) state_d = S_ALIGN;
            end
            S_ALIGN: state_d = S_SUB;
            S_SUB:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_PACK;
            S_PACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fp16_sub_seq.sv
// Directed bench for fp16_sub_seq: arithmetic vectors, specials, handshake and reset.
module tb_fp16_sub_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    fp16_sub_seq_if bus ();

    fp16_sub_seq dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (bus.ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        if (k >= 20) chk({tag, "_ready_timeout"}, 16'(bus.ready), 16'd1);
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
    endtask

    task automatic busy5(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_busy"}, {14'd0, bus.ready, bus.done}, 16'd0);
            step();
        end
    endtask

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] exp, input string tag);
        wait_ready(tag);
        issue(av, bv);
        busy5(tag);
        chk({tag, "_done"}, {14'd0, bus.ready, bus.done}, 16'd3);
        chk({tag, "_z"}, bus.z, exp);
    endtask

    logic [15:0] va [13] = '{16'h4200, 16'h3C00, 16'h8000, 16'h0000, 16'h3C00, 16'h3C00,
                             16'h7C00, 16'h7BFF, 16'h7C01, 16'h3C00, 16'h0000, 16'h4000,
                             16'h3C00};
    logic [15:0] vb [13] = '{16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 16'h1400, 16'h0C00,
                             16'h7C00, 16'hFBFF, 16'h3C00, 16'hFC00, 16'h3C00, 16'h4200,
                             16'hBC00};
    logic [15:0] vz [13] = '{16'h4000, 16'h0000, 16'h8000, 16'h0000, 16'h3BFE, 16'h3C00,
                             16'h7E00, 16'h7C00, 16'h7E00, 16'h7C00, 16'hBC00, 16'hBC00,
                             16'h4000};

    initial begin
        int dones;
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        step();
        step();
        rst = 1'b0;
        chk("reset_rdy_done", {14'd0, bus.ready, bus.done}, 16'd2);
        chk("reset_z", bus.z, 16'h0000);

        for (int i = 0; i < 13; i++)
            run_op(va[i], vb[i], vz[i], $sformatf("vec%0d", i));
        // subnormal subtrahend flushes to zero
        run_op(16'h3C00, 16'h0001, 16'h3C00, "ftz_b");
        step();
        chk("idle_after_done", {14'd0, bus.ready, bus.done}, 16'd2);

        // start while busy is dropped; exactly one done follows
        wait_ready("ign");
        issue(16'h4200, 16'h3C00);
        step();
        step();
        bus.a = 16'h7C01; bus.b = 16'h0000; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("ign_done", {14'd0, bus.ready, bus.done}, 16'd3);
        chk("ign_z", bus.z, 16'h4000);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done) dones++;
        end
        chk("ign_extra_dones", 16'(dones), 16'd0);

        // start held through the done cycle: second op accepted with no gap
        wait_ready("held");
        bus.a = 16'h4200; bus.b = 16'h3C00; bus.start = 1'b1;
        step();
        busy5("held1");
        chk("held1_done", {14'd0, bus.ready, bus.done}, 16'd3);
        chk("held1_z", bus.z, 16'h4000);
        bus.a = 16'h4000; bus.b = 16'h4200;
        step();
        bus.start = 1'b0;
        busy5("held2");
        chk("held2_done", {14'd0, bus.ready, bus.done}, 16'd3);
        chk("held2_z", bus.z, 16'hBC00);

        // reset mid-operation abandons the op and clears z
        wait_ready("rst");
        issue(16'h4200, 16'h3C00);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_rdy_done", {14'd0, bus.ready, bus.done}, 16'd2);
        chk("rst_mid_z", bus.z, 16'h0000);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done) dones++;
        end
        chk("rst_no_done", 16'(dones), 16'd0);
        run_op(16'h4200, 16'h3C00, 16'h4000, "after_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
